instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/load/execute sequencer for the accumulator CPU. It owns the program counter and drives the instruction ROM address. It latches each 15-bit instruction into an instruction register and presents the opcode and literal to the existing combinational opcode decoder. It then gates the decoder's register-load outputs into one-cycle write strobes, so regA/regB update exactly once per instruction.

## Interface
- PC_W, 8: program counter / ROM address width
- PROG_LAST, 255: address of last instruction; executing it halts the core
- OP_JMP, 7'b1010000: opcode handled locally as an unconditional jump to lit[PC_W-1:0]
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- run  in  1  level; 1 = free-run, 0 = stop at next instruction boundary
- restart  in  1  pulse; clears PC to 0 and leaves HALT
- im_addr  out  PC_W  ROM address (always equals pc)
- im_data  in  15  ROM read data, valid one cycle after im_addr
- ir_opcode  out  7  IR[14:8], to decoder
- ir_lit  out  8  IR[7:0], to literal mux
- dec_regA_load, dec_regB_load  in  1 each  decoder load requests for ir_opcode
- regA_we, regB_we  out  1 each  one-cycle write strobes
- exec  out  1  high during EXEC state
- halted  out  1  high in HALT
- pc  out  PC_W  current program counter
- step_mode, step  in  1 each  single-step controls (present only with SEQ_STEP_EN)

## Operation
- States: IDLE, FETCH, LOAD, EXEC, HALT. Encoding 3 bits, IDLE=0.
- IDLE: if restart, then pc<=0 and stay. Else if run=1 (and stepping not active), go to FETCH.
- FETCH: im_addr=pc is presented; the ROM samples it. Next state is LOAD.
- LOAD: IR<=im_data. Next state is EXEC.
- EXEC: exec=1.
  - Non-jump: regA_we=dec_regA_load, regB_we=dec_regB_load, pc<=pc+1.
  - Jump (ir_opcode==OP_JMP): both strobes forced 0, pc<=ir_lit[PC_W-1:0].
- EXEC exit, by priority:
  1. pc==PROG_LAST (before update): go to HALT; pc is still updated.
  2. run=0: go to IDLE.
  3. Otherwise: go to FETCH.
- HALT: halted=1. restart sets pc<=0 and goes to IDLE. run is ignored.
- restart in FETCH/LOAD/EXEC: ignored. The instruction completes.
- pc+1 wraps modulo 2^PC_W.
- regA_we/regB_we are never high outside EXEC.

## Timing
- Reset values: state=IDLE, pc=0, IR=0 (ir_opcode=0, ir_lit=0), regA_we=regB_we=exec=halted=0.
- Throughput: 3 cycles per instruction (FETCH, LOAD, EXEC) while run=1.
- Latency: run rising in IDLE gives first strobe 3 cycles later.
- Strobes and the pc update share the same EXEC clock edge. The ALU result presented during EXEC is the value written.
- rst_n low in any state, including mid-EXEC: return to reset values at that edge. No strobe is issued in that cycle, because reset wins over EXEC.
- run deasserted mid-instruction: the current instruction completes and the sequencer stops in IDLE.

## Configuration
- SEQ_STEP_EN defined:
  - step_mode and step ports exist.
  - With step_mode=1, IDLE ignores run and leaves only on a step pulse. The EXEC exit goes to IDLE (unless HALT applies), so each pulse runs exactly one instruction.
  - step pulses outside IDLE are dropped.
  - With step_mode=0, behaviour is identical to the undefined case.
- SEQ_STEP_EN undefined: ports are absent and the sequencer is controlled by run only.

## Structure
- Shared package cpu_pkg:
  - state typedef/localparams (ST_IDLE..ST_HALT)
  - OP_JMP
  - instruction field positions (OPC_HI=14, OPC_LO=8, LIT_HI=7)
- Sub-module pc_reg: PC_W-bit register with synchronous active-low clear, load (jump), increment, and clear (restart) controls.
- The FSM, IR and strobe gating stay in instr_sequencer.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with run=1. All outputs are at reset values; no strobe.
- Free-run: ROM[0]=MOV A,Lit 5 (dec_regA_load=1), ROM[1]=MOV B,Lit 3, run=1.
  - regA_we pulses on cycle 3 only; regB_we pulses on cycle 6.
  - pc reads 1 and then 2 after each EXEC.
- Jump: ROM[2]=OP_JMP with lit 0x00. After its EXEC, pc=0 with no strobes, and the next FETCH uses im_addr=0.
- Halt: PROG_LAST=3, program has no jumps. After EXEC at pc=3, halted=1 and pc=4, and the sequencer stays halted for 10 cycles with run=1. restart then gives IDLE with pc=0.
- Reset mid-EXEC: assert rst_n=0 during EXEC of a MOV A. regA_we stays 0 and pc=0 next cycle.
- Step (SEQ_STEP_EN): step_mode=1, run=1. Two step pulses 20 cycles apart give exactly two regA/regB strobes, and the sequencer returns to IDLE after each. A step pulse during LOAD is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU control path.
//   - seqState_t  : instruction sequencer states (3-bit, IDLE = 0)
//   - OP_JMP      : opcode executed inside the sequencer as an unconditional
//                   jump to the literal field
//   - OPC_HI/OPC_LO/LIT_HI : bit positions of the opcode and literal fields
//                   inside a 15-bit instruction word
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W = 15;
  localparam int OPC_HI  = 14;
  localparam int OPC_LO  = 8;
  localparam int LIT_HI  = 7;
  localparam int OPC_W   = OPC_HI - OPC_LO + 1;
  localparam int LIT_W   = LIT_HI + 1;

  localparam logic [OPC_W-1:0] OP_JMP = 7'b1010000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } seqState_t;

  // True when the opcode is the locally handled jump.
  function automatic logic isJumpOp(input logic [OPC_W-1:0] opcode);
    return opcode == OP_JMP;
  endfunction

endpackage : cpu_pkg

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register for the instruction sequencer.
// Priority (highest first): rst_n low, clear, load, inc. Increment wraps
// modulo 2^PC_W.
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset (pc -> 0)
//   clear      in   restart request, pc -> 0
//   load       in   jump, pc -> loadValue
//   inc        in   pc -> pc + 1
//   loadValue  in   PC_W jump target
//   pcValue    out  PC_W current program counter
// ---------------------------------------------------------------------------
module pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] loadValue,
  output logic [PC_W-1:0] pcValue
);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pcValue <= '0;
    end else if (load) begin
      pcValue <= loadValue;
    end else if (inc) begin
      pcValue <= pcValue + PC_W'(1);
    end
  end

endmodule : pc_reg

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle FETCH / LOAD / EXEC sequencer for the accumulator CPU. Owns the
// program counter, latches the ROM word into the instruction register, and
// turns the decoder's load requests into one-cycle register write strobes
// (exactly one EXEC cycle per instruction). OP_JMP is executed here.
//
// Optional feature: define SEQ_STEP_EN to add single-step control
// (step_mode, step). Without it the sequencer is controlled by run only.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   run            in   1 = free-run, 0 = stop at next instruction boundary
//   restart        in   pulse; in IDLE/HALT clears pc and leaves HALT
//   im_addr        out  PC_W ROM address (always pc)
//   im_data        in   15   ROM data, valid one cycle after im_addr
//   ir_opcode      out  7    IR[14:8] to the opcode decoder
//   ir_lit         out  8    IR[7:0] to the literal mux
//   dec_regA_load  in   decoder load request for regA
//   dec_regB_load  in   decoder load request for regB
//   regA_we        out  regA write strobe (EXEC only)
//   regB_we        out  regB write strobe (EXEC only)
//   exec           out  high during EXEC
//   halted         out  high in HALT
//   pc             out  PC_W current program counter
//   step_mode      in   (SEQ_STEP_EN) 1 = one instruction per step pulse
//   step           in   (SEQ_STEP_EN) step pulse, honoured only in IDLE
// ---------------------------------------------------------------------------
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int PROG_LAST = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               restart,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [OPC_W-1:0]   ir_opcode,
  output logic [LIT_W-1:0]   ir_lit,
  input  logic               dec_regA_load,
  input  logic               dec_regB_load,
  output logic               regA_we,
  output logic               regB_we,
  output logic               exec,
  output logic               halted,
`ifdef SEQ_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [PC_W-1:0]    pc
);

  seqState_t          state;
  logic [INSTR_W-1:0] ir;

  logic stepMode;   // EXEC always returns to IDLE when set
  logic startReq;   // condition that moves IDLE to FETCH
  logic isJump;
  logic atLast;
  logic pcClear;
  logic pcLoad;
  logic pcInc;

`ifdef SEQ_STEP_EN
  assign stepMode = step_mode;
  assign startReq = step_mode ? step : run;
`else
  assign stepMode = 1'b0;
  assign startReq = run;
`endif

  assign ir_opcode = ir[OPC_HI:OPC_LO];
  assign ir_lit    = ir[LIT_HI:0];
  assign isJump    = isJumpOp(ir_opcode);
  assign atLast    = (pc == PC_W'(PROG_LAST));
  assign im_addr   = pc;

  // restart is only honoured at instruction boundaries (IDLE or HALT).
  assign pcClear = restart && ((state == ST_IDLE) || (state == ST_HALT));
  assign pcLoad  = (state == ST_EXEC) && isJump;
  assign pcInc   = (state == ST_EXEC) && !isJump;

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pcClear),
    .load      (pcLoad),
    .inc       (pcInc),
    .loadValue (PC_W'(ir_lit)),
    .pcValue   (pc)
  );

  // Strobes are combinational from the registered exec flag so that the
  // register file writes on the same edge that advances pc. rst_n is folded
  // in because a synchronous reset landing on an EXEC edge must win: the
  // instruction is abandoned and nothing is written.
  assign regA_we = exec && rst_n && !isJump && dec_regA_load;
  assign regB_we = exec && rst_n && !isJump && dec_regB_load;

  // Sequencer FSM. exec and halted are registered alongside the state so
  // they are clean flop outputs that track the current state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: IR is reset (not left uninitialised) because its fields are
      // visible outputs feeding the decoder; a random opcode after reset
      // could request a load the moment EXEC is entered by other means.
      state  <= ST_IDLE;
      ir     <= '0;
      exec   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!restart && startReq) begin
            state <= ST_FETCH;
          end
        end

        // im_addr = pc is on the bus; the ROM samples it at this edge.
        ST_FETCH: begin
          state <= ST_LOAD;
        end

        ST_LOAD: begin
          ir    <= im_data;
          state <= ST_EXEC;
          exec  <= 1'b1;
        end

        // Exit priority: last instruction halts, then stepping / run low
        // return to IDLE, otherwise keep fetching.
        ST_EXEC: begin
          exec <= 1'b0;
          if (atLast) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (stepMode || !run) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_FETCH;
          end
        end

        ST_HALT: begin
          if (restart) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          exec   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule : instr_sequencer

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer with a small synchronous ROM model and a
// two-opcode decoder model (MOV A,Lit = 7'h01, MOV B,Lit = 7'h02).
// The DUT is built with PROG_LAST = 3 so the halt path is reachable quickly.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PC_W = 8;
  localparam logic [6:0] OPC_MOVA = 7'h01;
  localparam logic [6:0] OPC_MOVB = 7'h02;
  localparam logic [6:0] OPC_JUMP = 7'b1010000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic            restart;
  logic [PC_W-1:0] im_addr;
  logic [14:0]     im_data = '0;
  logic [6:0]      ir_opcode;
  logic [7:0]      ir_lit;
  logic            dec_regA_load;
  logic            dec_regB_load;
  logic            regA_we;
  logic            regB_we;
  logic            exec;
  logic            halted;
  logic [PC_W-1:0] pc;
`ifdef SEQ_STEP_EN
  logic            step_mode;
  logic            step;
`endif

  logic [14:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM: registered read, data valid the cycle after the address.
  always @(posedge clk) im_data <= rom[im_addr];

  assign dec_regA_load = (ir_opcode == OPC_MOVA);
  assign dec_regB_load = (ir_opcode == OPC_MOVB);

  instr_sequencer #(
    .PC_W      (PC_W),
    .PROG_LAST (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .restart       (restart),
    .im_addr       (im_addr),
    .im_data       (im_data),
    .ir_opcode     (ir_opcode),
    .ir_lit        (ir_lit),
    .dec_regA_load (dec_regA_load),
    .dec_regB_load (dec_regB_load),
    .regA_we       (regA_we),
    .regB_we       (regB_we),
    .exec          (exec),
    .halted        (halted),
`ifdef SEQ_STEP_EN
    .step_mode     (step_mode),
    .step          (step),
`endif
    .pc            (pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected per-cycle trace for the free-run / jump program after reset
  // release (index 0 = first cycle, FETCH of pc 0).
  int   expPc   [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
  logic expA    [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic expB    [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  logic expExec [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  // Absolute watchdog; normal runs finish far earlier.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aCount;
    int bCount;
    int bad;
    bit reached;

    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = {OPC_MOVA, 8'd5};
    rom[1] = {OPC_MOVB, 8'd3};
    rom[2] = {OPC_JUMP, 8'h00};

    rst_n   = 1'b0;
    run     = 1'b1;
    restart = 1'b0;
`ifdef SEQ_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif

    // ---- reset held two cycles with run high ----
    tick();
    tick();
    check("rst_pc", pc, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_opcode", ir_opcode, 0);
    check("rst_lit", ir_lit, 0);
    check("rst_exec", exec, 0);
    check("rst_halted", halted, 0);
    check("rst_regA_we", regA_we, 0);
    check("rst_regB_we", regB_we, 0);

    // ---- free-run, jump back to 0, then run dropped mid-instruction ----
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      check($sformatf("run_pc_c%0d", n + 1), pc, expPc[n]);
      check($sformatf("run_im_addr_c%0d", n + 1), im_addr, expPc[n]);
      check($sformatf("run_regA_we_c%0d", n + 1), regA_we, expA[n]);
      check($sformatf("run_regB_we_c%0d", n + 1), regB_we, expB[n]);
      check($sformatf("run_exec_c%0d", n + 1), exec, expExec[n]);
      if (n == 2) begin
        check("run_ir_opcode", ir_opcode, OPC_MOVA);
        check("run_ir_lit", ir_lit, 5);
      end
      if (n == 9) run = 1'b0;  // FETCH of the re-run instruction at pc 0
    end
    tick();
    tick();
    check("stop_exec", exec, 0);
    check("stop_pc", pc, 1);
    check("stop_halted", halted, 0);

    // ---- halt at PROG_LAST, stay halted, restart ----
    rom[2] = {OPC_MOVB, 8'd7};
    rom[3] = {OPC_MOVA, 8'd9};
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("idle_restart_pc", pc, 0);
    run     = 1'b1;
    aCount  = 0;
    bCount  = 0;
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      tick();
      if (regA_we) aCount++;
      if (regB_we) bCount++;
      if (halted) reached = 1'b1;
    end
    check("halt_reached", reached, 1);
    check("halt_pc", pc, 4);
    check("halt_regA_strobes", aCount, 2);
    check("halt_regB_strobes", bCount, 2);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!halted || pc != 8'd4 || exec || regA_we || regB_we) bad++;
    end
    check("halt_hold_violations", bad, 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    run     = 1'b0;
    check("halt_restart_halted", halted, 0);
    check("halt_restart_pc", pc, 0);
    check("halt_restart_exec", exec, 0);
    tick();
    check("halt_restart_idle", exec, 0);

    // ---- synchronous reset landing on an EXEC edge ----
    run = 1'b1;
    tick();
    tick();
    tick();
    check("rexec_exec", exec, 1);
    check("rexec_regA_before", regA_we, 1);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check("rexec_regA_gated", regA_we, 0);
    tick();
    check("rexec_pc", pc, 0);
    check("rexec_exec_after", exec, 0);
    check("rexec_opcode", ir_opcode, 0);
    check("rexec_regA_after", regA_we, 0);
    rst_n = 1'b1;

`ifdef SEQ_STEP_EN
    // ---- single-step: run ignored, one instruction per step pulse ----
    step_mode = 1'b1;
    run       = 1'b1;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (exec || pc != 8'd0) bad++;
    end
    check("step_idle_holds", bad, 0);
    aCount = 0;
    bCount = 0;
    step = 1'b1;
    tick();             // now FETCH
    step = 1'b0;
    tick();             // now LOAD
    step = 1'b1;        // dropped: not in IDLE
    tick();
    step = 1'b0;
    if (regA_we) aCount++;
    if (regB_we) bCount++;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (regA_we) aCount++;
      if (regB_we) bCount++;
    end
    check("step1_regA_strobes", aCount, 1);
    check("step1_regB_strobes", bCount, 0);
    check("step1_pc", pc, 1);
    check("step1_exec", exec, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (regA_we) aCount++;
      if (regB_we) bCount++;
    end
    check("step2_regA_strobes", aCount, 1);
    check("step2_regB_strobes", bCount, 1);
    check("step2_pc", pc, 2);
    check("step2_exec", exec, 0);
    step_mode = 1'b0;
    run       = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_sequencer
